// File: rtl/cc_parameter_bank.sv
// MIDI Control Change parameter bank: maps CC numbers onto parameter slots (7-bit or 14-bit
// MSB/LSB pairs) and reports every value change through a first-word-fall-through event FIFO.
module cc_parameter_bank #(
    parameter  int NUM_PARAMS  = 8,
    parameter  int VALUE_WIDTH = 14,
    parameter  int EVENT_DEPTH = 4,
    localparam int IDX_W       = $clog2(NUM_PARAMS)
) (
    input  logic                              clock_50_000_000,
    input  logic                              reset,
    input  logic                              message_valid,
    input  logic [7:0]                        message_status,
    input  logic [6:0]                        message_data1,
    input  logic [6:0]                        message_data2,
    input  logic [3:0]                        rx_channel,
    input  logic                              omni,
    input  logic [NUM_PARAMS*7-1:0]           cc_map,
    input  logic [NUM_PARAMS*VALUE_WIDTH-1:0] default_values,
    output logic [NUM_PARAMS*VALUE_WIDTH-1:0] parameters,
    output logic                              event_valid,
    output logic [IDX_W-1:0]                  event_index,
    output logic [VALUE_WIDTH-1:0]            event_value,
    input  logic                              event_ready,
    output logic                              reload_pulse,
    output logic                              overflow
);

    localparam int         PTR_W        = $clog2(EVENT_DEPTH);
    localparam int         CNT_W        = PTR_W + 1;
    localparam logic [3:0] STATUS_CC    = 4'hB;
    localparam logic [6:0] CC_RESET_ALL = 7'd121;

    typedef struct packed {
        logic [IDX_W-1:0]       index;
        logic [VALUE_WIDTH-1:0] value;
    } event_t;

    logic [VALUE_WIDTH-1:0] r_slots [NUM_PARAMS];
    event_t                 r_fifo  [EVENT_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_overflow;
    logic                   r_reload_pulse;

    logic                   w_accept;
    logic [NUM_PARAMS-1:0]  w_msb_match;
    logic [NUM_PARAMS-1:0]  w_lsb_match;
    logic                   w_hit;
    logic                   w_hit_lsb;
    logic [IDX_W-1:0]       w_hit_idx;
    logic [VALUE_WIDTH-1:0] w_old_value;
    logic [VALUE_WIDTH-1:0] w_new_value;
    logic                   w_change;
    logic                   w_reload;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;

    assign w_accept = message_valid && (message_status[7:4] == STATUS_CC) &&
                      (omni || (message_status[3:0] == rx_channel));

    // An LSB hit is data1 == map + 32, only for 14-bit slots whose map lies in the MSB range.
    for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_match
        logic [6:0] w_map;
        assign w_map = cc_map[7*gi +: 7];
        assign w_msb_match[gi] = (message_data1 == w_map);
        if (VALUE_WIDTH == 14) begin : g_lsb
            assign w_lsb_match[gi] = (w_map < 7'd32) && (message_data1 == w_map + 7'd32);
        end else begin : g_no_lsb
            assign w_lsb_match[gi] = 1'b0;
        end
        assign parameters[VALUE_WIDTH*gi +: VALUE_WIDTH] = r_slots[gi];
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_hit     = 1'b0;
        w_hit_lsb = 1'b0;
        w_hit_idx = '0;
        // Descending scan so the lowest matching index is the one left standing.
        for (int i = NUM_PARAMS - 1; i >= 0; i--) begin
            if (w_msb_match[i] || w_lsb_match[i]) begin
                w_hit     = w_accept;
                w_hit_lsb = w_lsb_match[i];
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    assign w_old_value = r_slots[w_hit_idx];

    if (VALUE_WIDTH == 14) begin : g_wide
        assign w_new_value = w_hit_lsb ? {w_old_value[13:7], message_data2}
                                       : {message_data2, 7'b0};
    end else begin : g_narrow
        assign w_new_value = message_data2;
    end

    assign w_change = w_hit && (w_new_value != w_old_value);
    assign w_reload = w_accept && !w_hit && (message_data1 == CC_RESET_ALL);

    assign w_full   = (r_count == CNT_W'(EVENT_DEPTH));
    assign w_pop    = (r_count != '0) && event_ready;
    assign w_push   = w_change && (!w_full || w_pop);
    assign w_drop   = w_change && w_full && !w_pop;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock_50_000_000) begin
        if (reset || w_reload) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                r_slots[i] <= default_values[VALUE_WIDTH*i +: VALUE_WIDTH];
            end
        end else if (w_change) begin
            r_slots[w_hit_idx] <= w_new_value;
        end
    end

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_overflow     <= 1'b0;
            r_reload_pulse <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_overflow     <= r_overflow || w_drop;
            r_reload_pulse <= w_reload;
        end
    end

    // NOTE: FIFO storage has no reset; r_count alone decides which entries are meaningful.
    always_ff @(posedge clock_50_000_000) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{index: w_hit_idx, value: w_new_value};
        end
    end

    assign event_valid  = (r_count != '0);
    assign event_index  = r_fifo[r_rd_ptr].index;
    assign event_value  = r_fifo[r_rd_ptr].value;
    assign reload_pulse = r_reload_pulse;
    assign overflow     = r_overflow;

endmodule

// File: doc/cc_parameter_bank.md
CC_PARAMETER_BANK -- requirements
Module: cc_parameter_bank

Interface
REQ-001 SHALL have parameter NUM_PARAMS, default 8: number of parameter slots (2..32).
REQ-002 SHALL have parameter VALUE_WIDTH, default 14: slot width; only 7 (coarse) or 14 (MSB/LSB) legal.
REQ-003 SHALL have parameter EVENT_DEPTH, default 4: change-event FIFO depth, power of 2 (>=2). IDX_W = clog2(NUM_PARAMS).
REQ-004 SHALL have ports, one per line:
- clock_50_000_000  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- message_valid  in  1  one-cycle strobe; one MIDI message per strobe.
- message_status  in  8  status byte.
- message_data1  in  7  controller number.
- message_data2  in  7  controller value.
- rx_channel  in  4  MIDI channel to accept.
- omni  in  1  1 = accept all channels.
- cc_map  in  NUM_PARAMS*7  slot i's controller number at bits [7i+6:7i].
- default_values  in  NUM_PARAMS*VALUE_WIDTH  per-slot reset/reload value.
- parameters  out  NUM_PARAMS*VALUE_WIDTH  slot i at [VW*i+VW-1:VW*i].
- event_valid  out  1  FIFO head holds a change event.
- event_index  out  IDX_W  slot that changed.
- event_value  out  VALUE_WIDTH  new slot value.
- event_ready  in  1  consumer pops head when event_valid & event_ready.
- reload_pulse  out  1  one-cycle pulse after Reset All Controllers.
- overflow  out  1  sticky: at least one event dropped.

Function
REQ-005 SHALL accept a message only if message_valid=1, message_status[7:4]=4'hB, and (omni=1 or message_status[3:0]=rx_channel); all else ignored, no state change.
REQ-006 SHALL update accepted-message state on the edge ending the message_valid cycle; parameters and FIFO reflect it in the next cycle (latency 1).
REQ-007 SHALL accept a new message every cycle; no backpressure on the message input.
REQ-008 Slot match: data1 equals cc_map slot i (MSB hit) or, when VALUE_WIDTH=14 and cc_map slot i <32, equals cc_map slot i +32 (LSB hit); multiple matches: lowest index wins.
REQ-009 VALUE_WIDTH=7: MSB hit writes slot = data2.
REQ-010 VALUE_WIDTH=14: MSB hit writes slot = {data2, 7'b0} (LSB cleared); LSB hit writes slot[6:0] = data2, slot[13:7] kept.
REQ-011 SHALL push {index, new value} into the event FIFO only when the new slot value differs from the old; equal writes update nothing and push nothing.
REQ-012 CC 121 (Reset All Controllers), accepted per REQ-005 and not mapped to a slot, SHALL load all slots from default_values, push no events, assert reload_pulse for exactly one cycle.
REQ-013 A cc_map entry of 121 SHALL take precedence as a slot write over REQ-012.
REQ-014 FIFO first-word-fall-through: event_valid high the cycle after a push into empty FIFO; event_index/event_value stable while event_valid & !event_ready.
REQ-015 Full FIFO and push without pop in the same cycle: drop new event, set overflow; slot still updated.
REQ-016 Full FIFO with push and pop in the same cycle: both take effect, no drop.
REQ-017 Empty FIFO: event_ready ignored; pointers wrap modulo EVENT_DEPTH.
REQ-018 overflow SHALL clear only on reset.

Reset
REQ-019 While reset=1: parameters = default_values, FIFO emptied, event_valid=0, reload_pulse=0, overflow=0; a message_valid coincident with reset is discarded.
REQ-020 First message accepted in the first cycle with reset=0.

Verification
REQ-021 NUM_PARAMS=8, VW=14, slot2 map=7, default 0, rx_channel=0: msg B0 07 40 -> next cycle slot2=0x2000, event {2,0x2000}; then B0 27 05 -> slot2=0x2005, event {2,0x2005}.
REQ-022 Repeat B0 07 40 with slot2=0x2000 -> no event, slot2 unchanged; B1 07 10 with omni=0 -> ignored; with omni=1 -> slot2=0x0800.
REQ-023 EVENT_DEPTH=4, event_ready=0, five distinct changing writes -> 4 events held, fifth dropped, overflow=1, all 5 slot writes visible; drain returns events 1-4 in order.
REQ-024 FIFO full, event_ready=1 and new change same cycle -> no drop, overflow stays 0, count stays 4.
REQ-025 Slots modified, B0 79 00 -> next cycle all slots = default_values, reload_pulse high one cycle, no events.
REQ-026 reset asserted with 3 queued events and message_valid=1 -> event_valid=0, overflow=0, slots = defaults, message discarded.
